// File: rtl/icache_fill.sv
// Instruction-cache line fill engine: turns a cache miss into a QPI quad-I/O read
// (CMD, 6 address nibbles, dummy cycles) and streams the returned nibbles to the cache.
module icache_fill #(
  parameter int         PA          = 22,
  parameter int         LINE_LENGTH = 4,
  parameter logic [7:0] CMD         = 8'hEB,
  parameter int         DUMMY       = 4,
  parameter int         CSH         = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]  tag,
  input  logic                               flush_all,
  output logic [3:0]                         dread,
  output logic                               wstrobe_d,
  output logic                               busy,
  output logic                               qspi_cs_n,
  output logic                               qspi_clk_en,
  output logic [3:0]                         qspi_dout,
  output logic [3:0]                         qspi_oe,
  input  logic [3:0]                         qspi_din
);

  localparam int OFF = $clog2(LINE_LENGTH);
  localparam int NIB = LINE_LENGTH * 2;
  localparam int NW  = $clog2(NIB);
  localparam int CW  = 8;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [NW-1:0]   r_nib, w_nib;
  logic [23:0]     r_addr, w_addr;
  logic            r_cs_n, w_cs_n;
  logic            r_clk_en, w_clk_en;
  logic [3:0]      r_oe, w_oe;
  logic [3:0]      r_dout, w_dout;
  logic [3:0]      r_dread, w_dread;
  logic            r_wstrobe, w_wstrobe;
  logic            r_busy, w_busy;
  logic            w_abort;
  logic [23:0]     w_byte_addr;

  assign w_byte_addr = 24'(tag) << OFF;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + 1'b1;
    w_nib     = r_nib;
    w_addr    = r_addr;
    w_cs_n    = r_cs_n;
    w_clk_en  = r_clk_en;
    w_oe      = r_oe;
    w_dout    = r_dout;
    w_dread   = r_dread;
    w_wstrobe = 1'b0;
    w_abort   = flush_all && (r_state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (pull && !flush_all) begin
          w_state  = S_CMD;
          w_addr   = w_byte_addr;
          w_cs_n   = 1'b0;
          w_clk_en = 1'b1;
          w_oe     = 4'hF;
          w_dout   = CMD[7:4];
        end
      end
      S_CMD: begin
        if (r_cnt == '0) begin
          w_dout = CMD[3:0];
        end else begin
          w_state = S_ADDR;
          w_cnt   = '0;
          w_dout  = r_addr[23:20];
          w_addr  = {r_addr[19:0], 4'h0};
        end
      end
      S_ADDR: begin
        if (r_cnt == CW'(5)) begin
          w_state = S_DUMMY;
          w_cnt   = '0;
          w_oe    = 4'h0;
          w_dout  = 4'h0;
        end else begin
          w_dout = r_addr[23:20];
          w_addr = {r_addr[19:0], 4'h0};
        end
      end
      S_DUMMY: begin
        if (r_cnt == CW'(DUMMY - 1)) begin
          w_state = S_DATA;
          w_cnt   = '0;
          w_nib   = '0;
        end
      end
      S_DATA: begin
        w_cnt     = '0;
        w_dread   = qspi_din;
        w_wstrobe = 1'b1;
        w_nib     = r_nib + 1'b1;
        if (r_nib == NW'(NIB - 1)) begin
          w_state  = S_GAP;
          w_cs_n   = 1'b1;
          w_clk_en = 1'b0;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(CSH - 1)) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // A flush drops the partial line: no further strobes, bus released, chip select held off.
    if (w_abort) begin
      w_state   = S_GAP;
      w_cnt     = '0;
      w_wstrobe = 1'b0;
      w_cs_n    = 1'b1;
      w_clk_en  = 1'b0;
      w_oe      = 4'h0;
      w_dout    = 4'h0;
    end

    w_busy = (w_state != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_nib     <= '0;
      r_addr    <= '0;
      r_cs_n    <= 1'b1;
      r_clk_en  <= 1'b0;
      r_oe      <= 4'h0;
      r_dout    <= 4'h0;
      r_dread   <= 4'h0;
      r_wstrobe <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_nib     <= w_nib;
      r_addr    <= w_addr;
      r_cs_n    <= w_cs_n;
      r_clk_en  <= w_clk_en;
      r_oe      <= w_oe;
      r_dout    <= w_dout;
      r_dread   <= w_dread;
      r_wstrobe <= w_wstrobe;
      r_busy    <= w_busy;
    end
  end

  assign dread       = r_dread;
  assign wstrobe_d   = r_wstrobe;
  assign busy        = r_busy;
  assign qspi_cs_n   = r_cs_n;
  assign qspi_clk_en = r_clk_en;
  assign qspi_oe     = r_oe;
  assign qspi_dout   = r_dout;

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: flash and cache models, a scoreboard monitor for the QPI
// header and returned nibbles, and directed fill / flush / async-reset scenarios.
module tb_icache_fill;

  localparam int PA = 22, LL = 4, DUMMY = 4, CSH = 2, NIB = 8;
  localparam int TW = PA - 2;

  logic          clk = 1'b0;
  logic          reset, pull, flush_all;
  logic [TW-1:0] tag;
  logic [3:0]    qspi_din = 4'h0;
  logic [3:0]    dread, qspi_dout, qspi_oe;
  logic          wstrobe_d, busy, qspi_cs_n, qspi_clk_en;

  always #5 clk = ~clk;

  icache_fill #(.PA(PA), .LINE_LENGTH(LL), .CMD(8'hEB), .DUMMY(DUMMY), .CSH(CSH)) dut (
    .clk(clk), .reset(reset), .pull(pull), .tag(tag), .flush_all(flush_all),
    .dread(dread), .wstrobe_d(wstrobe_d), .busy(busy),
    .qspi_cs_n(qspi_cs_n), .qspi_clk_en(qspi_clk_en), .qspi_dout(qspi_dout),
    .qspi_oe(qspi_oe), .qspi_din(qspi_din)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [3:0]  exp_nib_q[$];
  int          exp_len_q[$];
  logic [31:0] exp_hdr_q[$];

  // Flash: counts SCK cycles under cs_n, drives data nibbles after header + dummy.
  logic [7:0] fl_bytes[4];
  int         fl_cnt = 0;

  function automatic logic [3:0] nib_of(input int j);
    logic [7:0] b;
    b = fl_bytes[j / 2];
    return (j % 2 != 0) ? b[3:0] : b[7:4];
  endfunction

  always @(posedge clk) begin
    if (qspi_cs_n) fl_cnt <= 0;
    else begin
      fl_cnt <= fl_cnt + 1;
      if (fl_cnt + 1 >= 8 + DUMMY && fl_cnt + 1 < 8 + DUMMY + NIB)
        qspi_din <= nib_of(fl_cnt + 1 - 8 - DUMMY);
    end
  end

  // Cache: nibble n lands at slot n^1; line valid on the final strobe.
  logic [31:0]   c_line;
  int            c_n;
  logic          c_valid;
  logic [TW-1:0] c_tag;
  wire           hit = c_valid && (c_tag == tag);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c_line <= '0; c_n <= 0; c_valid <= 1'b0; c_tag <= '0;
    end else begin
      if (flush_all) c_valid <= 1'b0;
      if (wstrobe_d) begin
        c_line[((c_n ^ 1) * 4) +: 4] <= dread;
        c_n <= c_n + 1;
        if (c_n == NIB - 1) begin
          c_valid <= 1'b1;
          c_tag   <= tag;
        end
      end else c_n <= 0;
    end
  end

  // Monitor: compares bus activity and strobes against the scoreboard queues.
  int          cyc = 0, acc_cyc = 0, blen = 0, hi_cnt = 0;
  logic        prev_busy = 1'b0, prev_ws = 1'b0, prev_cs = 1'b1, seen = 1'b0;
  logic [31:0] hdr = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        seen = 1'b0; hi_cnt = 0; blen = 0;
        prev_busy = 1'b0; prev_ws = 1'b0; prev_cs = 1'b1;
      end else begin
        if (busy && !prev_busy) acc_cyc = cyc;
        if (!qspi_cs_n) begin
          if (fl_cnt < 8) begin
            check("header_oe", 32'(qspi_oe), 32'hF);
            hdr = {hdr[27:0], qspi_dout};
            if (fl_cnt == 7) begin
              check("header_pending", 32'(exp_hdr_q.size() != 0), 32'd1);
              if (exp_hdr_q.size() != 0) check("qpi_header", hdr, exp_hdr_q.pop_front());
            end
          end else if (fl_cnt < 8 + DUMMY) begin
            check("dummy_oe_dout", 32'({qspi_oe, qspi_dout}), 32'h0);
          end else begin
            check("data_oe", 32'(qspi_oe), 32'h0);
          end
        end
        if (qspi_cs_n) hi_cnt++;
        else if (prev_cs) begin
          if (seen) check("cs_high_gap", 32'((hi_cnt >= CSH) ? CSH : hi_cnt), 32'(CSH));
          seen = 1'b1;
          hi_cnt = 0;
        end
        if (wstrobe_d) begin
          if (!prev_ws) check("first_strobe_latency", 32'(cyc - acc_cyc), 32'(2 + 6 + DUMMY + 1));
          check("strobe_pending", 32'(exp_nib_q.size() != 0), 32'd1);
          if (exp_nib_q.size() != 0) check("dread", 32'(dread), 32'(exp_nib_q.pop_front()));
          blen++;
        end else if (prev_ws) begin
          check("burst_pending", 32'(exp_len_q.size() != 0), 32'd1);
          if (exp_len_q.size() != 0) check("burst_len", 32'(blen), 32'(exp_len_q.pop_front()));
          blen = 0;
        end
        prev_busy = busy; prev_ws = wstrobe_d; prev_cs = qspi_cs_n;
      end
    end
  end

  // Stimulus side: load the flash and push the expected header, nibbles and burst length.
  task automatic expect_fill(input logic [TW-1:0] t, input logic [7:0] b0, b1, b2, b3,
                             input int n);
    logic [31:0] stream;
    fl_bytes = '{b0, b1, b2, b3};
    stream   = {b0, b1, b2, b3};
    exp_hdr_q.push_back({8'hEB, 2'b00, t, 2'b00});
    for (int j = 0; j < n; j++) exp_nib_q.push_back(stream[31 - 4 * j -: 4]);
    exp_len_q.push_back(n);
  endtask

  task automatic wait_hit(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hit && n < 100);
  endtask

  int n;

  initial begin
    reset = 1'b1; pull = 1'b0; flush_all = 1'b0; tag = '0;
    #1;
    check("reset_outputs",
          32'({qspi_cs_n, qspi_clk_en, qspi_oe, qspi_dout, dread, wstrobe_d, busy}), 32'h8000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_reset", 32'({qspi_cs_n, busy, wstrobe_d, qspi_clk_en}), 32'b1000);
    end

    // Basic fill: A = 24'h048D14, header E B 0 4 8 D 1 4.
    tag = 20'h12345;
    expect_fill(tag, 8'h13, 8'h57, 8'h9B, 8'hDF, 8);
    pull = 1'b1;
    wait_hit(n);
    check("hit_latency", 32'(n), 32'd22);
    check("halfword0", 32'(c_line[15:0]), 32'h5713);
    check("halfword2", 32'(c_line[31:16]), 32'hDF9B);
    pull = 1'b0;
    repeat (10) @(negedge clk);
    check("no_refill", 32'({busy, qspi_cs_n}), 32'b01);

    // Highest tag: A = 24'h3FFFFC.
    tag = 20'hFFFFF;
    expect_fill(tag, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8);
    pull = 1'b1;
    wait_hit(n);
    check("hit_latency_maxtag", 32'(n), 32'd22);
    check("halfword0_maxtag", 32'(c_line[15:0]), 32'h3CA5);
    check("halfword2_maxtag", 32'(c_line[31:16]), 32'hF00F);
    pull = 1'b0;
    repeat (10) @(negedge clk);
    check("no_refill_maxtag", 32'({busy, qspi_cs_n}), 32'b01);

    // Flush during the 3rd data nibble: two strobes, then a full refill with pull held.
    tag = 20'h0ABCD;
    expect_fill(tag, 8'h12, 8'h34, 8'h56, 8'h78, 2);
    expect_fill(tag, 8'h12, 8'h34, 8'h56, 8'h78, 8);
    pull = 1'b1;
    repeat (15) @(negedge clk);
    flush_all = 1'b1;
    @(negedge clk);
    flush_all = 1'b0;
    check("flush_outputs", 32'({wstrobe_d, qspi_cs_n, qspi_clk_en, qspi_oe, busy}), 32'h41);
    check("flush_no_hit", 32'(hit), 32'd0);
    wait_hit(n);
    check("refill_hit_latency", 32'(n), 32'(CSH + 1 + 21));
    check("halfword0_refill", 32'(c_line[15:0]), 32'h3412);
    check("halfword2_refill", 32'(c_line[31:16]), 32'h7856);
    pull = 1'b0;
    repeat (10) @(negedge clk);

    // Async reset in the address phase, then a fresh fill from CMD.
    tag = 20'h00F0F;
    pull = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({qspi_cs_n, qspi_clk_en, qspi_oe, wstrobe_d, busy}), 32'h80);
    expect_fill(tag, 8'h01, 8'h23, 8'h45, 8'h67, 8);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_hit(n);
    check("hit_latency_after_reset", 32'(n), 32'd22);
    check("halfword0_after_reset", 32'(c_line[15:0]), 32'h2301);
    check("halfword2_after_reset", 32'(c_line[31:16]), 32'h6745);
    pull = 1'b0;
    repeat (10) @(negedge clk);
    check("no_refill_after_reset", 32'({busy, qspi_cs_n}), 32'b01);

    check("leftover_nibbles", 32'(exp_nib_q.size()), 32'd0);
    check("leftover_bursts", 32'(exp_len_q.size()), 32'd0);
    check("leftover_headers", 32'(exp_hdr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Memory-side fill engine for the instruction cache.
- Watches the cache's `pull`/`tag` miss request and runs a QPI quad-I/O read (cmd 0xEB) on the external flash/SRAM bus.
- Streams the returned line back to the cache as nibbles on `dread`/`wstrobe_d`, in the order the cache's nibble counter expects.
- Sits between the icache and the QSPI pad ring. `paddr` is held stable by the core while `pull` is high.

Parameters:
- PA, 22, physical address width in bits; must be ≤24.
- LINE_LENGTH, 4, cache line length in bytes; one fill returns LINE_LENGTH*2 nibbles.
- CMD, 8'hEB, quad read command opcode, sent in QPI form (2 nibbles).
- DUMMY, 4, dummy/turnaround cycles between the address and data phases (1..15).
- CSH, 2, minimum cycles `qspi_cs_n` stays high between transactions (≥1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- pull, input, 1, cache miss request (line needed).
- tag, input, PA-LOG2(LINE_LENGTH), line address: byte address = {tag, LOG2(LINE_LENGTH) zero bits}.
- flush_all, input, 1, cache flush; aborts any fill in progress.
- dread, output, 4, nibble to the cache (registered).
- wstrobe_d, output, 1, nibble valid (registered).
- busy, output, 1, high in any state other than IDLE.
- qspi_cs_n, output, 1, flash chip select, active low.
- qspi_clk_en, output, 1, pad ring gates clk onto SCK while high.
- qspi_dout, output, 4, nibble driven to the flash.
- qspi_oe, output, 4, per-line output enable.
- qspi_din, input, 4, nibble from the flash, sampled at posedge clk.

Behaviour:
- Reset (async): state=IDLE; qspi_cs_n=1; qspi_clk_en=0; qspi_oe=0; qspi_dout=0; dread=0; wstrobe_d=0; busy=0; counters=0.
- States: IDLE, CMD, ADDR, DUMMY, DATA, GAP. One nibble per clk in CMD, ADDR and DATA.
- IDLE: if pull=1 and flush_all=0 at a posedge:
  - latch the 24-bit byte address A = zero-extended {tag, 0s};
  - go to CMD; cs_n=0, clk_en=1, oe=4'hF.
- CMD, 2 cycles: qspi_dout = CMD[7:4], then CMD[3:0]. Then go to ADDR.
- ADDR, 6 cycles: qspi_dout = A[23:20], A[19:16], …, A[3:0]. Then go to DUMMY.
- DUMMY, DUMMY cycles: oe=0, dout=0. Then go to DATA.
- DATA, LINE_LENGTH*2 cycles: oe=0. Each posedge registers dread<=qspi_din and wstrobe_d<=1.
  - wstrobe_d is therefore high for exactly LINE_LENGTH*2 consecutive cycles, starting the cycle after DATA is entered. There are no gaps: the cache restarts its nibble count whenever wstrobe_d drops.
  - Nibble order is memory order, high nibble of each byte first (byte0[7:4], byte0[3:0], byte1[7:4], …). This matches the cache's offset^1 placement, so cache bits [7:4] receive the first nibble.
- After the last data sample, go to GAP: cs_n=1, clk_en=0; wstrobe_d falls the following cycle.
- GAP, CSH cycles: then return to IDLE. pull is ignored while in GAP.
- The cache sets the line valid on the final strobe, so `pull` falls one cycle after the last wstrobe_d. No spurious refill occurs because GAP ≥1 cycle.
- pull dropping mid-fill: the fill still completes (the line is still written).
- flush_all=1 in any state other than IDLE/GAP: at the next posedge:
  - wstrobe_d<=0, cs_n<=1, clk_en<=0, oe<=0;
  - go to GAP; the partial line is discarded (the cache never validates it).
- flush_all=1 together with pull in IDLE: stay in IDLE.
- Reset mid-transaction: all outputs idle immediately (async), no partial strobes after reset.
- Counters wrap only via state exit; the nibble counter is LOG2(LINE_LENGTH*2) bits wide.
- busy follows state registered (no combinational path from pull).

Test Plan:
- Reset held, then released with pull=0 -> cs_n=1, wstrobe_d=0, busy=0 indefinitely.
- pull=1, tag=20'h12345 (A=24'h048D14), DUMMY=4 -> qspi_dout sequence E,B,0,4,8,D,1,4; 4 dummy cycles with oe=0; then 8 consecutive wstrobe_d.
- Flash returns bytes 0x13,0x57,0x9B,0xDF -> dread=1,3,5,7,9,B,D,F. The cache then reads halfword 0x5713 at offset 0 and 0xDF9B at offset 2, and hit rises the cycle after the last strobe.
- Latency check -> first wstrobe_d exactly 2+6+DUMMY+1 = 13 cycles after the posedge where pull is accepted; cs_n high for ≥CSH cycles before the next cs_n fall.
- flush_all pulsed during the 3rd data nibble -> wstrobe_d low next cycle, cs_n=1, line not valid, and a refill is issued after CSH cycles with pull still high.
- Async reset asserted mid-ADDR -> cs_n=1, oe=0 without waiting for clk; after release, a fresh fill starts from CMD.
